// File: rtl/fetch_pkg.sv
// Shared types for the instruction-fetch sequencer: FSM states and branch opcodes.
package fetch_pkg;

  typedef enum logic [2:0] {
    FETCH,
    ISSUE,
    UPDATE,
    SETTLE,
    HALT,
    FAULT
  } state_t;

  localparam logic [3:0] OP_BRF  = 4'hA;
  localparam logic [3:0] OP_BRB  = 4'hB;
  localparam logic [3:0] OP_BRZ  = 4'hC;
  localparam logic [3:0] OP_HALT = 4'hF;

endpackage

// File: rtl/fetch_decode.sv
// Maps an instruction's opcode/immediate (plus the zero flag) onto the PC's
// one-hot inc/add/sub controls and offset operand.
module fetch_decode
  import fetch_pkg::*;
#(
  parameter int AW = 16,
  parameter int IW = 16
) (
  input  logic [3:0]    opcode,
  input  logic [IW-5:0] imm,
  input  logic          zero_flag,
  output logic          inc,
  output logic          add,
  output logic          sub,
  output logic [AW-1:0] offset
);

  always_comb begin
    inc    = 1'b0;
    add    = 1'b0;
    sub    = 1'b0;
    offset = '0;
    case (opcode)
      OP_BRF: begin
        add    = 1'b1;
        offset = AW'(imm);
      end
      OP_BRB: begin
        sub    = 1'b1;
        offset = AW'(imm);
      end
      OP_BRZ: begin
        if (zero_flag) begin
          add    = 1'b1;
          offset = AW'(imm);
        end else begin
          inc    = 1'b1;
          offset = AW'(1);
        end
      end
      default: begin
        inc    = 1'b1;
        offset = AW'(1);
      end
    endcase
  end

endmodule

// File: rtl/fetch_seq.sv
// Instruction-fetch sequencer: fetch at pc, issue to execute, then step or branch
// the program counter. Traps to FAULT when memory fails to ack in time.
module fetch_seq
  import fetch_pkg::*;
#(
  parameter int AW       = 16,
  parameter int IW       = 16,
  parameter int MAX_WAIT = 255
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [AW-1:0] pc,
  output logic          imem_req,
  output logic [AW-1:0] imem_addr,
  input  logic          imem_ack,
  input  logic [IW-1:0] imem_data,
  input  logic          zero_flag,
  output logic [IW-1:0] instr,
  output logic          instr_vld,
  input  logic          instr_rdy,
  output logic          inc,
  output logic          add,
  output logic          sub,
  output logic [AW-1:0] offset,
  output logic          halted,
  output logic          fault
);

  localparam int WW = (MAX_WAIT > 1) ? $clog2(MAX_WAIT) : 1;

  state_t        state;
  logic [WW-1:0] wait_cnt;
  logic          d_inc, d_add, d_sub;
  logic [AW-1:0] d_offset;
  logic          upd;

  // imem_req/addr are registered so the cycle after reset is fully quiet; FETCH
  // entered with req low spends one cycle raising it, SETTLE raises it on exit.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= FETCH;
      wait_cnt  <= '0;
      imem_req  <= 1'b0;
      imem_addr <= '0;
      instr     <= '0;
    end else begin
      case (state)
        FETCH: begin
          if (!imem_req) begin
            imem_req  <= 1'b1;
            imem_addr <= pc;
          end else if (imem_ack) begin
            instr     <= imem_data;
            wait_cnt  <= '0;
            imem_req  <= 1'b0;
            imem_addr <= '0;
            state     <= ISSUE;
          end else if (wait_cnt == WW'(MAX_WAIT - 1)) begin
            wait_cnt  <= '0;
            imem_req  <= 1'b0;
            imem_addr <= '0;
            state     <= FAULT;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        ISSUE: begin
          if (instr[IW-1 -: 4] == OP_HALT) begin
            state <= HALT;
          end else if (instr_rdy) begin
            state <= UPDATE;
          end
        end
        UPDATE: state <= SETTLE;
        SETTLE: begin
          imem_req  <= 1'b1;
          imem_addr <= pc;
          state     <= FETCH;
        end
        HALT:    state <= HALT;
        FAULT:   state <= FAULT;
        default: state <= FAULT;
      endcase
    end
  end

  fetch_decode #(
    .AW(AW),
    .IW(IW)
  ) u_decode (
    .opcode   (instr[IW-1 -: 4]),
    .imm      (instr[IW-5:0]),
    .zero_flag(zero_flag),
    .inc      (d_inc),
    .add      (d_add),
    .sub      (d_sub),
    .offset   (d_offset)
  );

  // Pulses are qualified by UPDATE so zero_flag is sampled in that cycle.
  assign upd       = (state == UPDATE);
  assign inc       = upd & d_inc;
  assign add       = upd & d_add;
  assign sub       = upd & d_sub;
  assign offset    = upd ? d_offset : '0;
  assign instr_vld = (state == ISSUE);
  assign halted    = (state == HALT);
  assign fault     = (state == FAULT);

endmodule

// File: tb/tb_fetch_seq.sv
// Self-checking bench for fetch_seq: directed scenarios plus randomized programs
// checked against a transaction-level PC/branch model.
module tb_fetch_seq;

  localparam int AW = 16;
  localparam int IW = 16;
  localparam int MW = 4;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic [AW-1:0] pc = '0;
  logic          imem_req;
  logic [AW-1:0] imem_addr;
  logic          imem_ack = 1'b0;
  logic [IW-1:0] imem_data = '0;
  logic          zero_flag = 1'b0;
  logic [IW-1:0] instr;
  logic          instr_vld;
  logic          instr_rdy = 1'b0;
  logic          inc, add, sub;
  logic [AW-1:0] offset;
  logic          halted, fault;

  int            n_tests = 0;
  int            n_fail = 0;
  logic [AW-1:0] exp_pc = '0;

  always #5 clk = ~clk;

  fetch_seq #(
    .AW      (AW),
    .IW      (IW),
    .MAX_WAIT(MW)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .pc       (pc),
    .imem_req (imem_req),
    .imem_addr(imem_addr),
    .imem_ack (imem_ack),
    .imem_data(imem_data),
    .zero_flag(zero_flag),
    .instr    (instr),
    .instr_vld(instr_vld),
    .instr_rdy(instr_rdy),
    .inc      (inc),
    .add      (add),
    .sub      (sub),
    .offset   (offset),
    .halted   (halted),
    .fault    (fault)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // One clock; the bench plays the PC register and applies any pulse at the edge.
  task automatic cyc();
    logic [AW-1:0] nxt;
    #1;
    nxt = pc;
    if (inc)      nxt = pc + 16'd1;
    else if (add) nxt = pc + offset;
    else if (sub) nxt = pc - offset;
    @(posedge clk);
    #1;
    pc = nxt;
    check("one_pulse", 32'($countones({inc, add, sub}) <= 1), 32'd1);
    check("req_vs_vld", 32'(imem_req & instr_vld), 32'd0);
    if (!(inc | add | sub)) check("idle_offset", 32'(offset), 32'd0);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_ctl"}, 32'({imem_req, instr_vld, inc, add, sub, halted, fault}), 32'd0);
    check({tag, "_offset"}, 32'(offset), 32'd0);
    check({tag, "_addr"}, 32'(imem_addr), 32'd0);
    check({tag, "_instr"}, 32'(instr), 32'd0);
  endtask

  // Reset in whatever state the DUT is in; returns at the first req cycle.
  task automatic do_reset(input logic [AW-1:0] start_pc);
    reset     = 1'b1;
    imem_ack  = 1'b0;
    instr_rdy = 1'b0;
    cyc();
    reset = 1'b0;
    check_all_zero("reset");
    pc     = start_pc;
    exp_pc = start_pc;
    cyc();
  endtask

  // Run one instruction from its first req cycle to the next instruction's req cycle.
  task automatic exec(input logic [IW-1:0] word, input bit zf, input int ack_dly,
                      input int rdy_dly, output bit stopped);
    logic [3:0]    op;
    logic [11:0]   imm;
    logic [2:0]    exp_pulse;
    logic [AW-1:0] exp_off;
    logic [AW-1:0] nxt;
    stopped = 1'b0;
    check("fetch_req", 32'(imem_req), 32'd1);
    check("fetch_addr", 32'(imem_addr), 32'(exp_pc));
    imem_ack = 1'b0;
    for (int i = 0; i < ack_dly; i++) begin
      cyc();
      check("wait_req", 32'(imem_req), 32'd1);
      check("wait_addr", 32'(imem_addr), 32'(exp_pc));
    end
    imem_ack  = 1'b1;
    imem_data = word;
    cyc();
    imem_ack  = 1'b0;
    imem_data = IW'($urandom);
    check("issue_vld", 32'(instr_vld), 32'd1);
    check("issue_instr", 32'(instr), 32'(word));
    check("issue_req", 32'(imem_req), 32'd0);
    op  = word[15:12];
    imm = word[11:0];
    if (op == 4'hF) begin
      cyc();
      check("halted", 32'(halted), 32'd1);
      check("halt_vld", 32'(instr_vld), 32'd0);
      check("halt_req", 32'(imem_req), 32'd0);
      stopped = 1'b1;
      return;
    end
    zero_flag = zf;
    instr_rdy = 1'b0;
    for (int i = 0; i < rdy_dly; i++) begin
      cyc();
      check("hold_vld", 32'(instr_vld), 32'd1);
      check("hold_instr", 32'(instr), 32'(word));
      check("hold_pulse", 32'({inc, add, sub}), 32'd0);
    end
    instr_rdy = 1'b1;
    cyc();
    instr_rdy = 1'b0;
    // Reference: branch target from the instruction set rules; pulse order {inc,add,sub}.
    case (op)
      4'hA:    begin nxt = exp_pc + {4'b0, imm}; exp_pulse = 3'b010; exp_off = {4'b0, imm}; end
      4'hB:    begin nxt = exp_pc - {4'b0, imm}; exp_pulse = 3'b001; exp_off = {4'b0, imm}; end
      4'hC: begin
        if (zf) begin nxt = exp_pc + {4'b0, imm}; exp_pulse = 3'b010; exp_off = {4'b0, imm}; end
        else    begin nxt = exp_pc + 16'd1;       exp_pulse = 3'b100; exp_off = 16'd1;        end
      end
      default: begin nxt = exp_pc + 16'd1;       exp_pulse = 3'b100; exp_off = 16'd1;        end
    endcase
    check("upd_pulse", 32'({inc, add, sub}), 32'(exp_pulse));
    check("upd_offset", 32'(offset), 32'(exp_off));
    check("upd_vld", 32'(instr_vld), 32'd0);
    exp_pc = nxt;
    cyc();
    check("settle_pulse", 32'({inc, add, sub}), 32'd0);
    check("settle_req", 32'(imem_req), 32'd0);
    cyc();
    check("next_req", 32'(imem_req), 32'd1);
    check("next_addr", 32'(imem_addr), 32'(exp_pc));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
    $fatal(1);
  end

  initial begin
    bit            stp;
    int            r;
    logic [3:0]    op;
    logic [IW-1:0] w;

    // Single-cycle fetch, plain opcode: inc in cycle 3, req again in cycle 5.
    do_reset(16'h0000);
    exec(16'h1234, 1'b0, 0, 0, stp);

    // Forward branch from 0x0010 lands on 0x0015.
    do_reset(16'h0010);
    exec(16'hA005, 1'b0, 0, 0, stp);
    check("brf_target", 32'(imem_addr), 32'h0015);

    // Conditional branch both ways, backward branch, zero-offset self loop.
    exec(16'hC003, 1'b0, 1, 0, stp);
    exec(16'hC003, 1'b1, 0, 1, stp);
    exec(16'hB002, 1'b0, 2, 0, stp);
    exec(16'hA000, 1'b0, 0, 0, stp);
    check("selfloop_addr", 32'(imem_addr), 32'(pc));

    // Execute stalls for 7 cycles.
    exec(16'h3ABC, 1'b0, 0, 7, stp);

    // Memory never acks: fault after MW req cycles; ack afterwards is ignored.
    do_reset(16'h0020);
    for (int i = 0; i < MW; i++) begin
      check("to_req", 32'(imem_req), 32'd1);
      cyc();
    end
    imem_ack = 1'b1;
    for (int i = 0; i < 3; i++) begin
      check("fault", 32'(fault), 32'd1);
      check("fault_req", 32'(imem_req), 32'd0);
      check("fault_vld", 32'(instr_vld), 32'd0);
      cyc();
    end
    imem_ack = 1'b0;

    // Halt instruction, then halt is sticky.
    do_reset(16'h0030);
    exec(16'hF000, 1'b0, 0, 0, stp);
    cyc();
    check("halt_sticky", 32'({halted, imem_req, fault}), 32'b100);

    // Reset while waiting on memory, then while in UPDATE.
    do_reset(16'h0040);
    cyc();
    cyc();
    do_reset(16'h0040);
    exec(16'h2000, 1'b0, 0, 0, stp);
    imem_ack  = 1'b1;
    imem_data = 16'hA005;
    cyc();
    imem_ack  = 1'b0;
    instr_rdy = 1'b1;
    cyc();
    instr_rdy = 1'b0;
    check("pre_rst_add", 32'({inc, add, sub}), 32'b010);
    do_reset(16'h0050);
    exec(16'hB001, 1'b0, 0, 0, stp);

    // Randomized programs.
    do_reset(16'($urandom));
    for (int n = 0; n < 150; n++) begin
      r = $urandom_range(0, 39);
      if (r == 0)      op = 4'hF;
      else if (r < 10) op = 4'hA;
      else if (r < 20) op = 4'hB;
      else if (r < 30) op = 4'hC;
      else             op = 4'($urandom_range(0, 9));
      w = {op, 12'($urandom)};
      exec(w, 1'($urandom), $urandom_range(0, MW - 1), $urandom_range(0, 3), stp);
      if (stp) do_reset(16'($urandom));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
